fifo_unpack_tx: RTL
===================

Name: fifo_unpack_tx

Overview:
- Width down-converter and byte serializer on the transmit path. It is the counterpart of the 8-to-256 prefetch FIFO on the receive side.
- Accepts wide result words (default 256 b) from the accelerator and emits them as a byte stream (default 8 b) to the UART transmitter.
- Buffers up to DEPTH_WORDS whole words, so the producer can hand off a result while the previous one is still shifting out.
- Single clock domain.

Parameters:
- IN_WIDTH, 256: input word width. Must be an integer multiple of OUT_WIDTH.
- OUT_WIDTH, 8: output byte width.
- DEPTH_WORDS, 2: word buffer depth. Power of two, 2..16.
- LSB_FIRST, 1: 1 sends in_data[OUT_WIDTH-1:0] first; 0 sends the top slice first.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: reset. Asynchronous assert, active-high.
- flush, input, 1: synchronous clear of buffer and serializer, active-high.
- in_vld, input, 1: producer word valid.
- in_rdy, output, 1: buffer can accept a word.
- in_data, input, IN_WIDTH: producer word.
- out_vld, output, 1: out_data holds a valid byte.
- out_rdy, input, 1: UART TX accepts the byte.
- out_data, output, OUT_WIDTH: current byte, registered.
- word_cnt, output, clog2(DEPTH_WORDS)+1: words held in the buffer, excluding the word being serialized.
- busy, output, 1: buffer non-empty or serializer holds a word.

Behaviour:
- Reset (async, rst=1), all registers cleared:
  - in_rdy=0 while rst is high; in_rdy=1 on the first clock after release.
  - out_vld=0, out_data=0, word_cnt=0, busy=0, byte index=0.
  - Reset mid-word discards all data; no partial byte is emitted after release.
- Derived constant: RATIO = IN_WIDTH/OUT_WIDTH (32 by default). Byte index counter width is clog2(RATIO).
- Input handshake:
  - A word is written when in_vld && in_rdy.
  - in_rdy = (word_cnt < DEPTH_WORDS) && !flush. It is a registered-count comparison with no combinational path from out_rdy.
  - in_data is ignored when in_vld=0.
- Serializer FSM:
  - IDLE: no word held, out_vld=0.
    - If the buffer is non-empty: load the head word into the shift register, set index=0, go to SEND.
    - out_vld rises in the cycle after the load.
  - SEND: out_vld=1, out_data = slice[index], LSB slice first when LSB_FIRST=1.
    - On out_vld && out_rdy with index<RATIO-1: index+1, next slice registered for the next cycle. Throughput is 1 byte/clk.
    - On the last byte accepted with the buffer non-empty: load the next word in the same cycle, index=0, stay in SEND. No bubble.
    - On the last byte accepted with the buffer empty: go to IDLE, out_vld=0 next cycle.
  - out_data and out_vld are held stable while out_vld && !out_rdy.
- Latency: a word written at cycle N into an empty block gives out_vld=1 at cycle N+2. The buffer write lands at N+1 and the serializer load follows at N+1 → byte visible N+2.
- Buffer: circular, with write and read pointers and wrap-around at DEPTH_WORDS.
  - A buffer write and a serializer pop in the same cycle leave word_cnt unchanged.
  - When full, in_rdy=0. There is no write-through while full, even if a pop occurs that cycle.
- flush=1 at a clock edge: buffer emptied, serializer to IDLE, out_vld=0, word_cnt=0 next cycle. A concurrent input word is not accepted because in_rdy=0 while flush is high.
- busy = (word_cnt!=0) || (state==SEND).
- Assertions:
  - No write when word_cnt==DEPTH_WORDS.
  - out_data stable while stalled.
  - IN_WIDTH % OUT_WIDTH == 0, checked at elaboration.

Test Plan:
- Single word 0x1F1E...0100 (byte k = k), out_rdy=1 → out_vld high at N+2; bytes 0x00..0x1F over 32 consecutive cycles; busy falls after byte 0x1F.
- Two words back-to-back (bytes 0x00..0x1F, then 0x20..0x3F), out_rdy=1 → 64 contiguous bytes 0x00..0x3F with no out_vld gap at the word boundary.
- out_rdy held 0 with 3 words offered (DEPTH_WORDS=2) → the first word moves to the serializer, two more are accepted, word_cnt=2, in_rdy=0; out_data stays 0x00 and stable for the full stall.
- out_rdy toggled randomly (50%) across 8 words of random data → every byte is seen exactly once, in order; word_cnt never exceeds 2.
- flush at byte index 10 of word 1, word 2 buffered → out_vld=0 and word_cnt=0 next cycle; a subsequent word 0xAA..AA gives 32 bytes of 0xAA only.
- rst asserted mid-word at byte index 5 → out_vld=0 and busy=0 immediately (async); after release in_rdy=1 and no stale bytes appear; LSB_FIRST=0 variant sends byte 0x1F first.

Source files
------------

// File: rtl/fifo_unpack_tx.sv
// Transmit-side width down-converter: buffers wide result words and serializes
// them into OUT_WIDTH slices for the UART transmitter.
module fifo_unpack_tx #(
    parameter int IN_WIDTH    = 256,
    parameter int OUT_WIDTH   = 8,
    parameter int DEPTH_WORDS = 2,
    parameter int LSB_FIRST   = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_vld,
    output logic                         in_rdy,
    input  logic [IN_WIDTH-1:0]          in_data,
    output logic                         out_vld,
    input  logic                         out_rdy,
    output logic [OUT_WIDTH-1:0]         out_data,
    output logic [$clog2(DEPTH_WORDS):0] word_cnt,
    output logic                         busy
);
    localparam int RATIO = IN_WIDTH / OUT_WIDTH;
    localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int PTR_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(RATIO - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH_WORDS);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    if (IN_WIDTH % OUT_WIDTH != 0) begin : g_width_check
        $error("IN_WIDTH must be an integer multiple of OUT_WIDTH");
    end

    logic [IN_WIDTH-1:0]  mem [DEPTH_WORDS];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [IN_WIDTH-1:0]  shift_reg;
    logic [IDX_W-1:0]     byte_idx;
    logic [0:0]           state;
    logic                 rdy_en;
    logic                 wr_en;
    logic                 pop;
    logic                 last_accept;

    function automatic logic [OUT_WIDTH-1:0] head_slice(input logic [IN_WIDTH-1:0] w);
        if (LSB_FIRST != 0)
            return w[OUT_WIDTH-1:0];
        return w[IN_WIDTH-1 -: OUT_WIDTH];
    endfunction

    function automatic logic [IN_WIDTH-1:0] drop_slice(input logic [IN_WIDTH-1:0] w);
        if (LSB_FIRST != 0)
            return w >> OUT_WIDTH;
        return w << OUT_WIDTH;
    endfunction

    // rdy_en keeps in_rdy low during reset and until the first clock after release
    assign in_rdy      = rdy_en && (word_cnt < DEPTH_CNT) && !flush;
    assign wr_en       = in_vld && in_rdy;
    assign last_accept = (state == SEND) && out_rdy && (byte_idx == LAST_IDX);
    assign pop         = !flush && (word_cnt != '0) && ((state == IDLE) || last_accept);
    assign out_vld     = (state == SEND);
    assign busy        = (word_cnt != '0) || (state == SEND);

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= in_data;
    end

    // Loading on the last accepted byte keeps back-to-back words gap-free
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_en    <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            word_cnt  <= '0;
            state     <= IDLE;
            byte_idx  <= '0;
            out_data  <= '0;
            shift_reg <= '0;
        end else begin
            rdy_en <= 1'b1;
            if (flush) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                word_cnt  <= '0;
                state     <= IDLE;
                byte_idx  <= '0;
                out_data  <= '0;
                shift_reg <= '0;
            end else begin
                if (wr_en)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                case ({wr_en, pop})
                    2'b10:   word_cnt <= word_cnt + 1'b1;
                    2'b01:   word_cnt <= word_cnt - 1'b1;
                    default: ;
                endcase
                if (pop) begin
                    state     <= SEND;
                    byte_idx  <= '0;
                    out_data  <= head_slice(mem[rd_ptr]);
                    shift_reg <= drop_slice(mem[rd_ptr]);
                end else if (state == SEND && out_rdy) begin
                    if (byte_idx == LAST_IDX) begin
                        state <= IDLE;
                    end else begin
                        byte_idx  <= byte_idx + 1'b1;
                        out_data  <= head_slice(shift_reg);
                        shift_reg <= drop_slice(shift_reg);
                    end
                end
            end
        end
    end

    a_no_write_when_full: assert property (@(posedge clk) disable iff (rst)
        !(wr_en && (word_cnt == DEPTH_CNT)));

    a_stable_when_stalled: assert property (@(posedge clk) disable iff (rst || flush)
        (out_vld && !out_rdy) |=> (out_vld && $stable(out_data)));

endmodule
